// File: rtl/reaction_timer_ctrl.sv
// ---------------------------------------------------------------------------
// reaction_timer_ctrl
//
// Top-level sequencer for the reaction-timer game. A 1 kHz square wave from
// the clock divider is the millisecond time base. A round runs a
// pseudo-random pre-delay, lights the stimulus LED, then counts the player's
// response in milliseconds. Early presses and timeouts are flagged. The
// result is handed to the display logic.
//
// Optional feature (compile-time macro BEST_TIME_EN):
//   defined   - BestMs tracks the minimum valid reaction time since reset.
//   undefined - BestMs is tied to 14'h3FFF and no best-time logic is built.
//
// Ports:
//   Clk       in   system clock (50 MHz)
//   Rst       in   synchronous reset, active-high
//   MsClk     in   1 kHz square wave, synchronous to Clk
//   Start     in   debounced start button (level)
//   React     in   debounced reaction button (level)
//   LedOn     out  stimulus LED
//   Elapsed   out  measured reaction time in ms, 0..MAX_MS
//   Valid     out  high while Elapsed holds a good result (DONE)
//   EarlyErr  out  high while in EARLY
//   Timeout   out  high while in TIMEOUT
//   BestMs    out  best (minimum) valid time since reset
//   StateOut  out  current state encoding
// ---------------------------------------------------------------------------
module reaction_timer_ctrl #(
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RAND_BITS    = 12,
    parameter int          MAX_MS       = 9999,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MsClk,
    input  logic        Start,
    input  logic        React,
    output logic        LedOn,
    output logic [13:0] Elapsed,
    output logic        Valid,
    output logic        EarlyErr,
    output logic        Timeout,
    output logic [13:0] BestMs,
    output logic [2:0]  StateOut
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DELAY   = 3'd1,
        ARMED   = 3'd2,
        DONE    = 3'd3,
        EARLY   = 3'd4,
        TIMEOUT = 3'd5
    } state_t;

    localparam logic [13:0] MAX_W = 14'(MAX_MS);

    state_t      state, state_nxt;
    logic        msclk_p0, start_p0, react_p0;
    logic        tick, start_pulse, react_pulse;
    logic [15:0] lfsr, lfsr_nxt;
    logic [15:0] delay_cnt, delay_nxt;
    logic [13:0] elapsed, elapsed_nxt;

    // Millisecond count step, saturating at the ceiling so Elapsed never wraps.
    function automatic logic [13:0] sat_inc(input logic [13:0] v);
        if (v >= MAX_W)
            return MAX_W;
        else
            return v + 14'd1;
    endfunction

    // Pre-delay: fixed part plus the low RAND_BITS of the LFSR, 16-bit sum.
    function automatic logic [15:0] delay_load(input logic [15:0] r);
        return 16'(MIN_DELAY_MS) + 16'(r[RAND_BITS-1:0]);
    endfunction

    // ---- stage p0: input edge registers ----
    // While Rst is high these follow their inputs, so a level held across
    // reset is already "seen" at release and produces no edge.
    always_ff @(posedge Clk) begin
        msclk_p0 <= MsClk;
        start_p0 <= Start;
        react_p0 <= React;
    end

    assign tick        = MsClk & ~msclk_p0;
    assign start_pulse = Start & ~start_p0;
    assign react_pulse = React & ~react_p0;

    // Fibonacci LFSR, taps 16,14,13,11; a nonzero seed keeps it off zero.
    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    always_comb begin
        state_nxt   = state;
        delay_nxt   = delay_cnt;
        elapsed_nxt = elapsed;
        case (state)
            IDLE, DONE, EARLY, TIMEOUT: begin
                if (start_pulse) begin
                    state_nxt   = DELAY;
                    delay_nxt   = delay_load(lfsr);
                    elapsed_nxt = '0;
                end
            end
            DELAY: begin
                if (react_pulse) begin
                    state_nxt = EARLY;
                end else if (tick) begin
                    // <= 1 also covers a zero load so the counter cannot wrap.
                    if (delay_cnt <= 16'd1) begin
                        state_nxt   = ARMED;
                        delay_nxt   = '0;
                        elapsed_nxt = '0;
                    end else begin
                        delay_nxt = delay_cnt - 16'd1;
                    end
                end
            end
            ARMED: begin
                // A press wins over a same-cycle tick; Elapsed freezes as-is.
                if (react_pulse) begin
                    state_nxt = DONE;
                end else if (tick) begin
                    elapsed_nxt = sat_inc(elapsed);
                    if (sat_inc(elapsed) == MAX_W)
                        state_nxt = TIMEOUT;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---- stage p1: state and datapath registers ----
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            lfsr      <= LFSR_SEED;
            delay_cnt <= '0;
            elapsed   <= '0;
            LedOn     <= 1'b0;
        end else begin
            state     <= state_nxt;
            lfsr      <= lfsr_nxt;
            delay_cnt <= delay_nxt;
            elapsed   <= elapsed_nxt;
            LedOn     <= (state_nxt == ARMED);
        end
    end

    assign Elapsed  = elapsed;
    assign Valid    = (state == DONE);
    assign EarlyErr = (state == EARLY);
    assign Timeout  = (state == TIMEOUT);
    assign StateOut = state;

`ifdef BEST_TIME_EN
    logic [13:0] best;

    // Updated on the same edge that enters DONE, i.e. the cycle Valid rises.
    always_ff @(posedge Clk) begin
        if (Rst)
            best <= 14'h3FFF;
        else if (state == ARMED && state_nxt == DONE && elapsed < best)
            best <= elapsed;
    end

    assign BestMs = best;
`else
    assign BestMs = 14'h3FFF;
`endif

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reaction_timer_ctrl
//
// Directed bench for reaction_timer_ctrl with MIN_DELAY_MS=5, RAND_BITS=2,
// MAX_MS=20 and an MsClk period of 10 Clk cycles. Expected values are worked
// out by hand from the tick counts of each step; a reference LFSR supplies
// the random part of each pre-delay.
// ---------------------------------------------------------------------------
module tb_reaction_timer_ctrl;

    localparam int MIN_D = 5;
    localparam int MAXMS = 20;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        MsClk = 1'b0;
    logic        Start;
    logic        React;
    logic        LedOn;
    logic [13:0] Elapsed;
    logic        Valid;
    logic        EarlyErr;
    logic        Timeout;
    logic [13:0] BestMs;
    logic [2:0]  StateOut;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m;
    logic [13:0] exp_best;
    int          cap;

    reaction_timer_ctrl #(
        .MIN_DELAY_MS(MIN_D),
        .RAND_BITS   (2),
        .MAX_MS      (MAXMS),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .MsClk   (MsClk),
        .Start   (Start),
        .React   (React),
        .LedOn   (LedOn),
        .Elapsed (Elapsed),
        .Valid   (Valid),
        .EarlyErr(EarlyErr),
        .Timeout (Timeout),
        .BestMs  (BestMs),
        .StateOut(StateOut)
    );

    always #5 Clk = ~Clk;

    // MsClk edges sit 2 ns before a rising Clk edge, well away from negedges.
    initial begin
        #3;
        forever #50 MsClk = ~MsClk;
    end

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting each cycle.
    always @(posedge Clk) begin
        if (Rst)
            m <= 16'hACE1;
        else
            m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for n ticks, then settle to the following Clk negedge.
    task automatic ticks(input int n);
        repeat (n) @(posedge MsClk);
        @(negedge Clk);
    endtask

    // Press Start at a negedge where the LFSR low bits equal want (any if <0).
    task automatic press_start(input int want, output int c);
        int n;
        n = 0;
        @(negedge Clk);
        while (want >= 0 && int'(m[1:0]) != want && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $error("FAIL lfsr_search: observed no match, expected low bits %0d", want);
        end
        c = int'(m[1:0]);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Called at a negedge; React is high for exactly one Clk cycle.
    task automatic press_react();
        React = 1'b1;
        @(negedge Clk);
        React = 1'b0;
    endtask

    // React asserted just before a tick edge, so ReactP and Tick coincide.
    task automatic react_on_tick();
        @(posedge MsClk);
        React = 1'b1;
        @(negedge Clk);
        React = 1'b0;
    endtask

    task automatic note_result(input int ms);
`ifdef BEST_TIME_EN
        if (14'(ms) < exp_best) exp_best = 14'(ms);
`else
        if (ms < 0) exp_best = 14'h0;
`endif
    endtask

    task automatic do_round(input int ms);
        int c;
        press_start(-1, c);
        chk("round_state_delay", 16'(StateOut), 16'd1);
        chk("round_valid_clr", 16'(Valid), 16'd0);
        chk("round_elapsed_clr", 16'(Elapsed), 16'd0);
        ticks(MIN_D + c);
        chk("round_led_on", 16'(LedOn), 16'd1);
        ticks(ms);
        press_react();
        note_result(ms);
        chk("round_state_done", 16'(StateOut), 16'd3);
        chk("round_elapsed", 16'(Elapsed), 16'(ms));
        chk("round_valid", 16'(Valid), 16'd1);
        chk("round_best", 16'(BestMs), 16'(exp_best));
    endtask

    initial begin
        exp_best = 14'h3FFF;
        Rst   = 1'b1;
        Start = 1'b1;
        React = 1'b0;

        // Reset held 3 cycles with Start high; release must not start a round.
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_state", 16'(StateOut), 16'd0);
        chk("rst_led", 16'(LedOn), 16'd0);
        chk("rst_elapsed", 16'(Elapsed), 16'd0);
        chk("rst_valid", 16'(Valid), 16'd0);
        chk("rst_early", 16'(EarlyErr), 16'd0);
        chk("rst_timeout", 16'(Timeout), 16'd0);
        chk("rst_best", 16'(BestMs), 16'h3FFF);
        Start = 1'b0;
        @(negedge Clk);

        // Round 1: LFSR low bits 2 -> 7 ms delay, react after 12 ms.
        press_start(2, cap);
        chk("r1_state_delay", 16'(StateOut), 16'd1);
        chk("r1_cap", 16'(cap), 16'd2);
        ticks(6);
        chk("r1_led_before", 16'(LedOn), 16'd0);
        chk("r1_state_before", 16'(StateOut), 16'd1);
        ticks(1);
        chk("r1_led_on", 16'(LedOn), 16'd1);
        chk("r1_state_armed", 16'(StateOut), 16'd2);
        chk("r1_elapsed0", 16'(Elapsed), 16'd0);
        ticks(12);
        chk("r1_elapsed_run", 16'(Elapsed), 16'd12);
        press_react();
        note_result(12);
        chk("r1_state_done", 16'(StateOut), 16'd3);
        chk("r1_valid", 16'(Valid), 16'd1);
        chk("r1_elapsed", 16'(Elapsed), 16'd12);
        chk("r1_led_off", 16'(LedOn), 16'd0);
        chk("r1_best", 16'(BestMs), 16'(exp_best));
        press_react();
        chk("done_react_ignored", 16'(StateOut), 16'd3);

        // Early press 2 ms into the pre-delay.
        press_start(-1, cap);
        chk("e1_valid_clr", 16'(Valid), 16'd0);
        ticks(2);
        press_react();
        chk("e1_state", 16'(StateOut), 16'd4);
        chk("e1_flag", 16'(EarlyErr), 16'd1);
        chk("e1_led", 16'(LedOn), 16'd0);
        ticks(20);
        chk("e1_led_held", 16'(LedOn), 16'd0);
        chk("e1_state_held", 16'(StateOut), 16'd4);

        // Start from EARLY, then let the round time out.
        press_start(-1, cap);
        chk("t1_early_clr", 16'(EarlyErr), 16'd0);
        chk("t1_state_delay", 16'(StateOut), 16'd1);
        ticks(MIN_D + cap);
        chk("t1_led_on", 16'(LedOn), 16'd1);
        ticks(MAXMS - 1);
        chk("t1_elapsed19", 16'(Elapsed), 16'(MAXMS - 1));
        chk("t1_state_armed", 16'(StateOut), 16'd2);
        ticks(1);
        chk("t1_elapsed_max", 16'(Elapsed), 16'(MAXMS));
        chk("t1_timeout", 16'(Timeout), 16'd1);
        chk("t1_led_off", 16'(LedOn), 16'd0);
        chk("t1_state", 16'(StateOut), 16'd5);
        ticks(50);
        chk("t1_elapsed_hold", 16'(Elapsed), 16'(MAXMS));
        chk("t1_state_hold", 16'(StateOut), 16'd5);
        press_react();
        chk("t1_react_ignored", 16'(StateOut), 16'd5);
        chk("t1_best", 16'(BestMs), 16'(exp_best));

        // Further rounds for the best-time tracker.
        do_round(9);
        do_round(15);

        // ReactP and Tick on the same edge in ARMED at Elapsed=7.
        press_start(-1, cap);
        chk("c1_timeout_clr", 16'(Timeout), 16'd0);
        ticks(MIN_D + cap);
        chk("c1_led_on", 16'(LedOn), 16'd1);
        ticks(7);
        chk("c1_elapsed7", 16'(Elapsed), 16'd7);
        react_on_tick();
        note_result(7);
        chk("c1_state_done", 16'(StateOut), 16'd3);
        chk("c1_elapsed", 16'(Elapsed), 16'd7);
        chk("c1_best", 16'(BestMs), 16'(exp_best));

        // ReactP and Tick on the same edge in DELAY.
        press_start(-1, cap);
        react_on_tick();
        chk("c2_state_early", 16'(StateOut), 16'd4);
        chk("c2_flag", 16'(EarlyErr), 16'd1);
        ticks(10);
        chk("c2_led_off", 16'(LedOn), 16'd0);

        // Reset in the middle of an armed round.
        press_start(-1, cap);
        ticks(MIN_D + cap);
        chk("m1_led_on", 16'(LedOn), 16'd1);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        exp_best = 14'h3FFF;
        chk("m1_state", 16'(StateOut), 16'd0);
        chk("m1_led", 16'(LedOn), 16'd0);
        chk("m1_elapsed", 16'(Elapsed), 16'd0);
        chk("m1_valid", 16'(Valid), 16'd0);
        chk("m1_best", 16'(BestMs), 16'(exp_best));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
